// File: rtl/spi_master_pkg.sv
// Shared FSM encoding and default divider for the byte-wide SPI master.
package spi_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_DONE
    } spi_state_t;

    localparam int SPI_CLK_DIV = 4;

endpackage

// File: rtl/spi_master.sv
// Byte-wide full-duplex SPI master, run-time CPOL/CPHA and bit order.
// All outputs are registered; mode and data are latched at start.
module spi_master
    import spi_master_pkg::*;
#(
    parameter int CLK_DIV = SPI_CLK_DIV
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       done,
    input  logic [7:0] D_in,
    output logic [7:0] D_out,
    input  logic       CPOL,
    input  logic       CPHA,
    input  logic       MSBfirst,
    input  logic       MISO,
    output logic       MOSI,
    output logic       SCLK,
    output logic       SS
);

    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_MID  = DW'(CLK_DIV / 2 - 1);

    spi_state_t r_state;
    spi_state_t w_next;

    logic [DW-1:0] r_div;
    logic [2:0]    r_bit;
    logic [7:0]    r_tx;
    logic [7:0]    r_rx;
    logic [7:0]    r_dout;
    logic          r_cpol;
    logic          r_cpha;
    logic          r_msb;
    logic          r_busy;
    logic          r_done;
    logic          r_mosi;
    logic          r_sclk;
    logic          r_ss;

    logic       w_slot_end;
    logic       w_mid;
    logic       w_last;
    logic       w_lead;
    logic [7:0] w_tx_sh;

    assign w_slot_end = (r_div == DIV_LAST);
    assign w_mid      = (r_div == DIV_MID);
    assign w_last     = w_slot_end && (r_bit == 3'd7);
    // SCLK level during the first half of every bit slot
    assign w_lead     = r_cpol ^ r_cpha;
    assign w_tx_sh    = r_msb ? {r_tx[6:0], 1'b0}
                              : {1'b0, r_tx[7:1]};

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:  if (start) w_next = ST_SETUP;
            ST_SETUP: w_next = ST_SHIFT;
            ST_SHIFT: if (w_last) w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div  <= '0;
            r_bit  <= '0;
            r_tx   <= '0;
            r_rx   <= '0;
            r_dout <= '0;
            r_cpol <= 1'b0;
            r_cpha <= 1'b0;
            r_msb  <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_mosi <= 1'b0;
            r_sclk <= 1'b0;
            r_ss   <= 1'b1;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    r_sclk <= CPOL;
                    if (start) begin
                        r_tx   <= D_in;
                        r_cpol <= CPOL;
                        r_cpha <= CPHA;
                        r_msb  <= MSBfirst;
                        r_busy <= 1'b1;
                        r_ss   <= 1'b0;
                        r_mosi <= MSBfirst ? D_in[7] : D_in[0];
                    end
                end
                ST_SETUP: begin
                    r_div  <= '0;
                    r_bit  <= '0;
                    r_sclk <= w_lead;
                end
                ST_SHIFT: begin
                    if (w_slot_end) begin
                        r_div <= '0;
                        if (w_last) begin
                            r_bit  <= '0;
                            r_done <= 1'b1;
                            r_ss   <= 1'b1;
                            r_sclk <= r_cpol;
                            r_dout <= r_rx;
                        end else begin
                            r_bit  <= r_bit + 3'd1;
                            r_tx   <= w_tx_sh;
                            r_mosi <= r_msb ? w_tx_sh[7] : w_tx_sh[0];
                            r_sclk <= w_lead;
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                        // second-half edge is the sampling edge in every mode
                        if (w_mid) begin
                            r_sclk <= ~w_lead;
                            r_rx   <= r_msb ? {r_rx[6:0], MISO}
                                            : {MISO, r_rx[7:1]};
                        end
                    end
                end
                ST_DONE: begin
                    r_done <= 1'b0;
                    r_busy <= 1'b0;
                    r_sclk <= CPOL;
                end
            endcase
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign D_out = r_dout;
    assign MOSI  = r_mosi;
    assign SCLK  = r_sclk;
    assign SS    = r_ss;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: modes 0-3, bit order, streaming,
// ignored start while busy and synchronous reset mid-transfer.
module tb_spi_master;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       busy;
    logic       done;
    logic [7:0] D_in;
    logic [7:0] D_out;
    logic       CPOL;
    logic       CPHA;
    logic       MSBfirst;
    logic       w_miso;
    logic       MOSI;
    logic       SCLK;
    logic       SS;
    logic       loop_en;
    logic       miso_drv;

    int checks = 0;
    int failures = 0;

    int t_busy, t_ss, t_rise, t_first, t_done, t_donec;
    int t_perr, t_merr;
    logic [7:0] t_mseq;
    logic [7:0] t_rst_dout;
    logic [3:0] t_rst_obs;
    logic       t_setup_mosi;
    logic       t_idle_sclk;

    int         nd;
    int         dc [4];
    logic [7:0] dv [4];

    always #5 clk = ~clk;

    assign w_miso = loop_en ? MOSI : miso_drv;

    spi_master #(.CLK_DIV(DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .D_in     (D_in),
        .D_out    (D_out),
        .CPOL     (CPOL),
        .CPHA     (CPHA),
        .MSBfirst (MSBfirst),
        .MISO     (w_miso),
        .MOSI     (MOSI),
        .SCLK     (SCLK),
        .SS       (SS)
    );

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // kind: 0 plain, 1 extra start pulse at cycle 'at', 2 reset at 'at'
    task automatic run(input logic pol, input logic pha,
                       input logic msb, input logic [7:0] din,
                       input logic [7:0] mb, input int kind,
                       input int at);
        logic ps, pm, lead;
        int k, d;
        t_busy = 0; t_ss = 0; t_rise = 0; t_first = -1;
        t_done = 0; t_donec = -1; t_perr = 0; t_merr = 0;
        t_mseq = '0; t_setup_mosi = 1'b0; t_idle_sclk = 1'b0;
        t_rst_obs = '0; t_rst_dout = '0;
        lead = pol ^ pha;
        CPOL = pol; CPHA = pha; MSBfirst = msb; D_in = din;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ps = SCLK; pm = MOSI;
        for (int c = 0; c < 45; c++) begin
            if (c > 0) @(negedge clk);
            if (busy) t_busy++;
            if (!SS) t_ss++;
            if (c == 0) t_setup_mosi = MOSI;
            if (c >= 1 && c <= 8 * DIV) begin
                k = (c - 1) / DIV;
                d = (c - 1) % DIV;
                if (SCLK !== ((d < DIV / 2) ? lead : ~lead)) t_perr++;
                if (d == 0) t_mseq = {t_mseq[6:0], MOSI};
                else if (MOSI !== pm) t_merr++;
                miso_drv = msb ? mb[7 - k] : mb[k];
            end
            if (c > 0 && SCLK && !ps) begin
                t_rise++;
                if (t_first < 0) t_first = c;
            end
            if (done) begin
                t_done++;
                t_donec = c;
                CPOL = pol; CPHA = pha; MSBfirst = msb; D_in = din;
            end
            if (c == 40) t_idle_sclk = SCLK;
            ps = SCLK; pm = MOSI;
            // mode/data pins wiggle mid-byte; the latched copy must win
            if (c == 1) begin
                CPOL = ~pol; CPHA = ~pha; MSBfirst = ~msb; D_in = ~din;
            end
            if (kind == 1 && c == at) start = 1'b1;
            if (kind == 1 && c == at + 1) start = 1'b0;
            if (kind == 2 && c == at) rst = 1'b1;
            if (kind == 2 && c == at + 1) begin
                t_rst_obs = {SS, busy, SCLK, done};
                t_rst_dout = D_out;
                rst = 1'b0;
                CPOL = pol; CPHA = pha; MSBfirst = msb; D_in = din;
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; CPOL = 1'b0; CPHA = 1'b0;
        MSBfirst = 1'b1; D_in = '0; loop_en = 1'b1; miso_drv = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ss", SS, 1);
        check("rst_sclk", SCLK, 0);
        check("rst_mosi", MOSI, 0);
        check("rst_dout", D_out, 0);
        rst = 1'b0;
        @(negedge clk);

        run(1'b0, 1'b0, 1'b1, 8'hA5, 8'h00, 0, 0);
        check("m0_mosi_seq", t_mseq, 8'hA5);
        check("m0_setup_mosi", t_setup_mosi, 1);
        check("m0_rises", t_rise, 8);
        check("m0_first_rise", t_first, 3);
        check("m0_done_cnt", t_done, 1);
        check("m0_done_cyc", t_donec, 33);
        check("m0_dout", D_out, 8'hA5);
        check("m0_busy_cyc", t_busy, 34);
        check("m0_ss_cyc", t_ss, 33);
        check("m0_phase", t_perr, 0);
        check("m0_mosi_stable", t_merr, 0);
        check("m0_idle_sclk", t_idle_sclk, 0);

        loop_en = 1'b0;
        run(1'b1, 1'b1, 1'b0, 8'h3C, 8'h81, 0, 0);
        loop_en = 1'b1;
        check("m3_mosi_seq", t_mseq, 8'h3C);
        check("m3_dout", D_out, 8'h81);
        check("m3_rises", t_rise, 8);
        check("m3_first_rise", t_first, 3);
        check("m3_phase", t_perr, 0);
        check("m3_idle_sclk", t_idle_sclk, 1);
        check("m3_done_cnt", t_done, 1);

        run(1'b0, 1'b1, 1'b1, 8'hF0, 8'h00, 0, 0);
        check("m1_phase", t_perr, 0);
        check("m1_mosi_stable", t_merr, 0);
        check("m1_mosi_seq", t_mseq, 8'hF0);
        check("m1_dout", D_out, 8'hF0);

        run(1'b1, 1'b0, 1'b0, 8'hF0, 8'h00, 0, 0);
        check("m2_phase", t_perr, 0);
        check("m2_mosi_stable", t_merr, 0);
        check("m2_mosi_seq", t_mseq, 8'h0F);
        check("m2_dout", D_out, 8'hF0);

        run(1'b0, 1'b0, 1'b1, 8'h5A, 8'h00, 1, 10);
        check("busy_start_done", t_done, 1);
        check("busy_start_busy", t_busy, 34);
        check("busy_start_dout", D_out, 8'h5A);

        run(1'b0, 1'b0, 1'b1, 8'hC3, 8'h00, 2, 17);
        check("midrst_outs", t_rst_obs, 4'b1000);
        check("midrst_dout", t_rst_dout, 0);
        check("midrst_no_done", t_done, 0);
        run(1'b0, 1'b0, 1'b1, 8'h69, 8'h00, 0, 0);
        check("after_rst_done", t_done, 1);
        check("after_rst_dout", D_out, 8'h69);
        check("after_rst_seq", t_mseq, 8'h69);

        CPOL = 1'b0; CPHA = 1'b0; MSBfirst = 1'b1;
        D_in = 8'hAE; start = 1'b1; nd = 0;
        for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            if (done) begin
                if (nd < 4) begin
                    dc[nd] = c;
                    dv[nd] = D_out;
                end
                nd++;
                if (nd == 1) D_in = 8'hD5;
                else if (nd == 2) D_in = 8'h80;
                else start = 1'b0;
            end
        end
        check("stream_count", nd, 3);
        check("stream_b0", dv[0], 8'hAE);
        check("stream_b1", dv[1], 8'hD5);
        check("stream_b2", dv[2], 8'h80);
        check("stream_gap0", dc[1] - dc[0], 35);
        check("stream_gap1", dc[2] - dc[1], 35);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- Byte-wide SPI master with run-time selectable CPOL/CPHA and bit order; full-duplex: shifts 8 bits out on MOSI while capturing 8 bits from MISO.
- Sits between a peripheral controller (e.g. the SSD1306 display driver) and the SPI pins.
- Controller holds start high and updates the data byte on each done pulse, giving back-to-back transfers.
- At CLK_DIV=4 a continuous stream costs 35 clk per byte (12 MHz clk -> 3 MHz SCLK).

Parameters:
- CLK_DIV, 4, clk cycles per SCLK period; even, >=2.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- start  in  1  level request; sampled only in IDLE
- busy  out  1  high in SETUP, SHIFT and DONE
- done  out  1  one-cycle pulse when a byte completes
- D_in  in  8  byte to transmit; latched when a transfer starts
- D_out  out  8  received byte; valid at done, held until next done
- CPOL  in  1  SCLK idle level
- CPHA  in  1  clock phase
- MSBfirst  in  1  1: bit 7 first; 0: bit 0 first
- MISO  in  1  serial data in
- MOSI  out  1  serial data out
- SCLK  out  1  serial clock
- SS  out  1  slave select, active low

Behaviour:
- Reset rst, synchronous, active-high; clock clk. Reset values: state IDLE, busy=0, done=0, SS=1, MOSI=0, SCLK=0, D_out=0, shift/bit/divider counters=0.
- rst mid-transfer: abort immediately, no done pulse, outputs return to reset values.
- All outputs are registered.
- FSM: IDLE -> SETUP -> SHIFT -> DONE -> IDLE.
- IDLE:
  - SCLK=CPOL, SS=1, busy=0.
  - If start=1 at the clock edge: latch D_in, CPOL, CPHA and MSBfirst; go to SETUP.
  - Latched values stay fixed for the whole byte, even if the inputs change.
- SETUP (1 cycle):
  - SS=0, SCLK=CPOL.
  - MOSI = first bit: D_in[7] if MSBfirst, else D_in[0].
- SHIFT (8*CLK_DIV cycles): bit slot k=0..7, each slot CLK_DIV cycles, split into two halves of CLK_DIV/2.
  - CPHA=0: SCLK=CPOL in the first half, ~CPOL in the second.
  - CPHA=1: SCLK=~CPOL in the first half, CPOL in the second.
  - MOSI carries bit k for the whole slot and changes only at slot boundaries.
  - MISO is sampled at the clock edge that starts the second half. In both modes this is the sampling edge of the SPI mode.
  - Received bits fill D_out from bit 7 down if MSBfirst, else from bit 0 up.
  - After the last slot go to DONE.
- DONE (1 cycle):
  - done=1, SS=1, SCLK=CPOL, busy=1.
  - D_out updated with the full received byte.
  - Go to IDLE.
- Continuous mode: if start is still high, the next transfer begins from the IDLE cycle after DONE. That IDLE cycle lets the controller present a new D_in registered on the done pulse.
  - Start-to-start period = 1 + 1 + 8*CLK_DIV + 1 = 35 clk at CLK_DIV=4.
- start in any state other than IDLE is ignored; no queuing.
- MOSI holds its last value outside SHIFT/SETUP until the next SETUP.
- Mode pins changing while busy have no effect until the next start.

Decomposition:
- Shared package: FSM state enum (IDLE, SETUP, SHIFT, DONE) and the default CLK_DIV constant.
- No sub-module. The divider counter, bit counter and tx/rx shift registers stay inline in one module.

Test Plan:
- Mode 0, MSBfirst=1, D_in=0xA5, MISO looped to MOSI, one start pulse.
  - SCLK idle low; 8 rising edges, first at 3 clk after SETUP.
  - MOSI sequence 1,0,1,0,0,1,0,1; done pulses once; D_out=0xA5.
  - busy high 34 cycles; SS low 33 cycles.
- Mode 3 (CPOL=1, CPHA=1), MSBfirst=0, D_in=0x3C, MISO driven by a model returning 0x81.
  - SCLK idle high; MOSI order 0,0,1,1,1,1,0,0.
  - MISO sampled on rising edges; D_out=0x81.
- Continuous stream: start held high; controller loads 0xAE, 0xD5, 0x80 on successive done pulses.
  - Bytes transmitted in order; done pulses spaced exactly 35 clk apart.
  - No byte repeated or skipped.
- start asserted while busy (pulsed mid-SHIFT) -> ignored; exactly one done; next transfer only after returning to IDLE.
- rst asserted at slot 4 of a transfer -> next cycle SS=1, busy=0, SCLK=0, no done; a new start afterwards completes normally.
- Mode 1 and Mode 2 with D_in=0xF0 -> SCLK phase matches the CPHA rule above; MOSI transitions coincide only with slot boundaries.
